// File: rtl/mmu_refill_if.sv
// Signal bundle between the MMU refill engine and its surroundings: the fault
// trigger, the page-table base register, the PTE memory port and the MMU write port.
interface mmu_refill_if #(
    parameter int RV = 16
);
    logic          start;
    logic [RV-1:0] fault_reg;
    logic          ptbase_we;
    logic [RV-1:0] ptbase_data;
    logic          mem_req;
    logic [RV-1:0] mem_addr;
    logic          mem_ack;
    logic [RV-1:0] mem_rdata;
    logic          mmu_reg_write;
    logic [RV-1:0] mmu_reg_data;
    logic          busy;
    logic          done;
    logic          trap;
    logic [1:0]    trap_cause;

    // master: the refill engine; slave: the core, memory and MMU around it
    modport master (
        input  start, fault_reg, ptbase_we, ptbase_data, mem_ack, mem_rdata,
        output mem_req, mem_addr, mmu_reg_write, mmu_reg_data, busy, done, trap, trap_cause
    );

    modport slave (
        output start, fault_reg, ptbase_we, ptbase_data, mem_ack, mem_rdata,
        input  mem_req, mem_addr, mmu_reg_write, mmu_reg_data, busy, done, trap, trap_cause
    );
endinterface

// File: rtl/mmu_refill.sv
// Hardware page-table walker: on a captured MMU fault it fetches the PTE for
// {ins, sup, vpage}, writes it back into the MMU, or raises a software trap.
module mmu_refill #(
    parameter int RV      = 16,
    parameter int PA      = 16,
    parameter int VA      = 16,
    parameter int NMMU    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    mmu_refill_if.master bus
);
    localparam int VPW = $clog2(NMMU);
    localparam int IW  = VPW + 2;
    localparam int BW  = RV - IW - 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] TRAP  = 3'd5;

    localparam logic [1:0] C_TIMEOUT = 2'b00;
    localparam logic [1:0] C_DISABLE = 2'b01;
    localparam logic [1:0] C_PROT    = 2'b10;
    localparam logic [1:0] C_INVALID = 2'b11;

    logic [2:0]     state;
    logic [BW-1:0]  r_base;
    logic           r_en;
    logic [VPW-1:0] r_vpage;
    logic           r_ins;
    logic           r_sup;
    logic           r_prot;
    logic [RV-1:0]  r_addr;
    logic [RV-1:0]  r_data;
    logic [1:0]     r_cause;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            r_base  <= '0;
            r_en    <= 1'b0;
            r_vpage <= '0;
            r_ins   <= 1'b0;
            r_sup   <= 1'b0;
            r_prot  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_cause <= '0;
            cnt     <= '0;
        end else begin
            if (bus.ptbase_we) begin
                r_base <= bus.ptbase_data[RV-1:IW+1];
                r_en   <= bus.ptbase_data[0];
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        r_vpage <= bus.fault_reg[VA-1:VA-VPW];
                        r_ins   <= bus.fault_reg[4];
                        r_sup   <= bus.fault_reg[3];
                        r_prot  <= bus.fault_reg[1];
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_prot) begin
                        r_cause <= C_PROT;
                        state   <= TRAP;
                    end else if (!r_en) begin
                        r_cause <= C_DISABLE;
                        state   <= TRAP;
                    end else begin
                        // address frozen here so base writes mid-walk cannot disturb it
                        r_addr <= {r_base, r_ins, r_sup, r_vpage, 1'b0};
                        cnt    <= '0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.mem_ack) begin
                        if (!bus.mem_rdata[1]) begin
                            r_cause <= C_INVALID;
                            state   <= TRAP;
                        end else begin
                            // bits [1:0]=11: entry valid, virt-write select
                            r_data <= {bus.mem_rdata[RV-1:3], bus.mem_rdata[2], 2'b11};
                            state  <= WRITE;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        r_cause <= C_TIMEOUT;
                        state   <= TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE:   state <= DONE;
                DONE:    state <= IDLE;
                TRAP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.mem_req       = (state == FETCH);
    assign bus.mem_addr      = r_addr;
    assign bus.mmu_reg_write = (state == WRITE);
    assign bus.mmu_reg_data  = r_data;
    assign bus.done          = (state == DONE);
    assign bus.trap          = (state == TRAP);
    assign bus.trap_cause    = r_cause;

    // fields of the fault/base/PTE words this engine does not consume
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.fault_reg, bus.ptbase_data, bus.mem_rdata[0], PA > 0};
endmodule

// File: tb/tb_mmu_refill.sv
// Directed bench for mmu_refill: stimulus queues expected events, a monitor
// compares every DUT event (request, MMU write, done, trap) in order and time.
module tb_mmu_refill;
    localparam int K_REQ  = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;
    localparam int K_TRAP = 3;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          rel;
    } exp_t;

    logic clk;
    logic reset;
    mmu_refill_if #(.RV(16)) bus ();

    mmu_refill #(.RV(16), .PA(16), .VA(16), .NMMU(8), .TIMEOUT(255)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   t0     = 0;
    logic prev_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, req);
    endtask

    task automatic push(input int k, input logic [15:0] v, input int r);
        exp_t e;
        e.kind = k; e.val = v; e.rel = r;
        q.push_back(e);
    endtask

    task automatic wait_to(input int rel);
        while (cyc < t0 + rel) @(negedge clk);
    endtask

    task automatic start_walk(input logic [15:0] f);
        @(negedge clk);
        bus.fault_reg = f;
        bus.start     = 1'b1;
        t0            = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic set_base(input logic [15:0] d);
        @(negedge clk);
        bus.ptbase_we   = 1'b1;
        bus.ptbase_data = d;
        @(negedge clk);
        bus.ptbase_we   = 1'b0;
    endtask

    task automatic ack(input logic [15:0] d);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = d;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
    endtask

    // monitor: one event per cycle at most, compared against queue head
    always @(negedge clk) begin
        int          k;
        logic [15:0] v;
        logic        ev;
        exp_t        e;
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            ev = 1'b0; k = 0; v = '0;
            if (bus.mem_req && !prev_req) begin ev = 1'b1; k = K_REQ;  v = bus.mem_addr;     end
            else if (bus.mmu_reg_write)   begin ev = 1'b1; k = K_WR;   v = bus.mmu_reg_data; end
            else if (bus.done)            begin ev = 1'b1; k = K_DONE; v = '0;               end
            else if (bus.trap)            begin ev = 1'b1; k = K_TRAP; v = {14'd0, bus.trap_cause}; end
            if (ev) begin
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind %0d val %h at rel %0d, want none", k, v, cyc - t0);
                end else begin
                    e = q.pop_front();
                    if (e.kind == k && e.val === v && e.rel == cyc - t0) n_pass++;
                    else $display("FAIL event: got kind %0d val %h rel %0d, want kind %0d val %h rel %0d",
                                  k, v, cyc - t0, e.kind, e.val, e.rel);
                end
            end
            prev_req = bus.mem_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nreq;
        reset = 1'b1;
        bus.start = 1'b0; bus.fault_reg = '0; bus.ptbase_we = 1'b0; bus.ptbase_data = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        #1;
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_mem_req", {15'd0, bus.mem_req}, 16'd0);
        check("rst_mem_addr", bus.mem_addr, 16'h0000);
        check("rst_reg_data", bus.mmu_reg_data, 16'h0000);
        check("rst_trap_cause", {14'd0, bus.trap_cause}, 16'd0);
        check("rst_strobes", {13'd0, bus.mmu_reg_write, bus.done, bus.trap}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // refill hit, zero-wait ack
        set_base(16'h1201);
        push(K_REQ, 16'h121A, 2); push(K_WR, 16'h6007, 3); push(K_DONE, 16'h0, 4);
        start_walk(16'hA008);
        check("hit_busy_c1", {15'd0, bus.busy}, 16'd1);
        wait_to(2); ack(16'h6006);
        wait_to(5);
        check("hit_busy_c5", {15'd0, bus.busy}, 16'd0);

        // protection fault
        push(K_TRAP, 16'd2, 2);
        start_walk(16'h4006);
        wait_to(4);
        check("prot_busy_c4", {15'd0, bus.busy}, 16'd0);

        // walker disabled
        set_base(16'h1200);
        push(K_TRAP, 16'd1, 2);
        start_walk(16'h0000);
        wait_to(4);

        // timeout: mem_req high for exactly 255 cycles
        set_base(16'h1201);
        push(K_REQ, 16'h121A, 2); push(K_TRAP, 16'd0, 257);
        start_walk(16'hA008);
        nreq = 0;
        repeat (300) begin
            if (bus.mem_req) nreq++;
            @(negedge clk);
        end
        check("timeout_req_cycles", nreq[15:0], 16'd255);

        // invalid PTE, one wait cycle
        push(K_REQ, 16'h1222, 2); push(K_TRAP, 16'd3, 4);
        start_walk(16'h2010);
        wait_to(3); ack(16'h8004);
        wait_to(6);
        check("invalid_cause_held", {14'd0, bus.trap_cause}, 16'd3);

        // second start / stray ack ignored, base write mid-fetch ignored
        push(K_REQ, 16'h121A, 2); push(K_WR, 16'hABCF, 6); push(K_DONE, 16'h0, 7);
        start_walk(16'hA008);
        bus.start = 1'b1; bus.fault_reg = 16'h4006; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0000;
        @(negedge clk);
        bus.start = 1'b0; bus.mem_ack = 1'b0;
        wait_to(3);
        bus.ptbase_we = 1'b1; bus.ptbase_data = 16'h3401;
        @(negedge clk);
        bus.ptbase_we = 1'b0;
        check("addr_stable", bus.mem_addr, 16'h121A);
        wait_to(5); ack(16'hABCE);
        wait_to(7);
        bus.start = 1'b1; bus.fault_reg = 16'h4006;
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(10);

        // async reset mid-fetch
        set_base(16'h1201);
        push(K_REQ, 16'h121A, 2);
        start_walk(16'hA008);
        wait_to(3);
        reset = 1'b1;
        #1;
        check("rst_mid_req", {15'd0, bus.mem_req}, 16'd0);
        check("rst_mid_busy", {15'd0, bus.busy}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_addr", bus.mem_addr, 16'h0000);
        check("rst_mid_data", bus.mmu_reg_data, 16'h0000);
        check("rst_mid_cause", {14'd0, bus.trap_cause}, 16'd0);
        // base cleared by reset: walk must trap as disabled
        push(K_TRAP, 16'd1, 2);
        start_walk(16'h0000);
        wait_to(6);

        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            $display("FAIL missing_event: got none, want kind %0d val %h rel %0d", e.kind, e.val, e.rel);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mmu_refill.md
Name: mmu_refill

Overview:
- Hardware refill engine for the paged MMU. It acts as the writer for the MMU register port.
- After the core captures a translation fault, it reads the MMU fault register and fetches a 16-bit PTE from an in-memory table indexed by {ins, sup, vpage}.
- A valid PTE is programmed back into the MMU with a virt-write, and the core is told to retry.
- Protection faults, invalid PTEs, a disabled walker and bus timeouts are escalated to a software trap instead.

Parameters:
RV, 16, register/data width
PA, 16, physical address width
VA, 16, virtual address width
NMMU, 8, MMU entries per context; index width IW = $clog2(NMMU)+2
TIMEOUT, 255, max cycles mem_req may wait for mem_ack

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: MMU fault has been captured
fault_reg  in  RV  MMU reg_read: [VA-1:VA-$clog2(NMMU)] vpage, [4] ins, [3] sup, [2] write, [1] valid(1=prot fault), [0] 0
ptbase_we  in  1  write page-table base register
ptbase_data  in  RV  [RV-1:IW+1] table base, [0] walker enable
mem_req  out  1  PTE read request
mem_addr  out  RV  PTE byte address
mem_ack  in  1  read complete, mem_rdata valid
mem_rdata  in  RV  PTE: [RV-1:3] phys page bits, [2] writeable, [1] valid
mmu_reg_write  out  1  MMU register write strobe
mmu_reg_data  out  RV  MMU register write data
busy  out  1  walk in progress
done  out  1  one-cycle pulse: entry loaded, retry access
trap  out  1  one-cycle pulse: software must handle
trap_cause  out  2  00 timeout, 01 walker disabled, 10 protection, 11 invalid PTE; valid with trap, held until next trap

Behaviour:
- Reset (async): state IDLE, r_ptbase=0 (walker disabled). All outputs are 0, including mem_addr, mmu_reg_data and trap_cause.
- ptbase_we loads r_ptbase in any state. The FETCH address is captured on entry to FETCH, so a later base write does not affect an in-flight walk.
- IDLE: busy=0. On start, latch fault_reg into r_fault and go to CHECK. A start while not in IDLE is ignored.
- CHECK (1 cycle, busy=1):
  - r_fault[1]=1 -> TRAP, cause 10.
  - else r_ptbase[0]=0 -> TRAP, cause 01.
  - else register mem_addr = {r_ptbase[RV-1:IW+1], ins, sup, vpage, 1'b0}, clear the timeout counter, go to FETCH.
- FETCH: mem_req=1, mem_addr held stable.
  - mem_ack (may occur in the first FETCH cycle): latch mem_rdata and drop mem_req. If PTE[1]=0 -> TRAP, cause 11; else go to WRITE.
  - No ack: the counter increments each cycle. When it reaches TIMEOUT without ack, drop mem_req -> TRAP, cause 00.
- WRITE (1 cycle): mmu_reg_write=1, mmu_reg_data = {PTE[RV-1:3], PTE[2], 1'b1, 1'b1}. Bit0=1 selects virt-write; the MMU's held fault fields supply the entry index. Go to DONE.
- DONE: done=1 for one cycle -> IDLE.
- TRAP: trap=1 for one cycle with trap_cause -> IDLE.
- mem_ack outside FETCH is ignored.
- Latency: start at cycle 0, CHECK at 1, mem_req first high at 2. Ack at cycle k gives mmu_reg_write at k+1 and done at k+2. With a zero-wait ack at cycle 2, done is at cycle 4.
- busy=1 in every state except IDLE.
- Reset asserted mid-FETCH drops mem_req immediately; the memory side must discard the transaction.

Test Plan:
- Refill hit (RV=16, NMMU=8): ptbase=0x1201; start with fault_reg=0xA008 (vpage 5, sup) -> mem_addr=0x121A. Ack at cycle 2 with rdata=0x6006 -> mmu_reg_write at cycle 3 with data 0x6007, done at cycle 4, busy low at cycle 5.
- Protection: fault_reg=0x4006 -> trap at cycle 2, cause 10, mem_req never asserted.
- Disabled: ptbase=0x1200, fault_reg=0x0000 -> trap at cycle 2, cause 01.
- Invalid PTE: ptbase=0x1201, fault_reg=0x2010 (vpage 1, ins) -> mem_addr=0x1222. rdata=0x8004 -> trap, cause 11, no mmu_reg_write.
- Timeout: mem_ack held low -> mem_req high for exactly TIMEOUT cycles, then trap, cause 00.
- Concurrency: second start and stray mem_ack while busy are ignored. ptbase_we during FETCH leaves mem_addr unchanged. Async reset mid-FETCH -> mem_req=0 immediately, state IDLE, r_ptbase=0.
